// File: rtl/uart_rx.sv
// UART receiver: oversampled serial-to-parallel converter with optional
// parity and stop-bit checking. Frame settings (PRESCALE, PAR_ENABLE,
// PAR_TYPE) are captured at start detection and held for the whole frame.
// Optional build macro UART_RX_MAJORITY_EN: each bit is the 2-of-3 majority
// of samples around mid-bit instead of a single mid-bit sample.
module uart_rx #(
   parameter int unsigned DATA_WIDTH  = 8,
   parameter int unsigned PRESC_WIDTH = 6
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic                   RX_IN,
   input  logic [PRESC_WIDTH-1:0] PRESCALE,
   input  logic                   PAR_ENABLE,
   input  logic                   PAR_TYPE,
   output logic [DATA_WIDTH-1:0]  P_DATA,
   output logic                   DATA_VALID,
   output logic                   PAR_ERR,
   output logic                   STP_ERR
);

   localparam int unsigned BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [PRESC_WIDTH-1:0] PRESC_MIN = PRESC_WIDTH'(8);
   localparam logic [PRESC_WIDTH-1:0] ONE       = PRESC_WIDTH'(1);
   localparam logic [BW-1:0]          LAST_BIT  = BW'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

   state_e                  state_q, state_d;
   logic [PRESC_WIDTH-1:0]  edge_cnt_q, edge_cnt_d;
   logic [BW-1:0]           bit_cnt_q, bit_cnt_d;
   logic [PRESC_WIDTH-1:0]  presc_q, presc_d;
   logic                    par_en_q, par_en_d;
   logic                    par_type_q, par_type_d;
   logic [DATA_WIDTH-1:0]   shift_q, shift_d;
   logic [DATA_WIDTH-1:0]   p_data_q, p_data_d;
   logic                    err_q, err_d;
   logic                    dv_q, dv_d;
   logic                    pe_q, pe_d;
   logic                    se_q, se_d;
   logic [PRESC_WIDTH-1:0]  half;
   logic                    bit_end;
   logic                    bit_val;

`ifdef UART_RX_MAJORITY_EN
   logic [2:0] samp_q, samp_d;
   assign bit_val = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) |
                    (samp_q[1] & samp_q[2]);
`else
   logic samp_q, samp_d;
   assign bit_val = samp_q;
`endif

   assign half    = presc_q >> 1;
   assign bit_end = (edge_cnt_q == presc_q - ONE);

   assign P_DATA     = p_data_q;
   assign DATA_VALID = dv_q;
   assign PAR_ERR    = pe_q;
   assign STP_ERR    = se_q;

   // State register
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) state_q <= StIdle;
      else      state_q <= state_d;
   end

   // Next-state logic: advance on bit ends, abort on false start
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (!RX_IN) state_d = StStart;
         StStart:  if (bit_end) state_d = bit_val ? StIdle : StData;
         StData:   if (bit_end && (bit_cnt_q == LAST_BIT)) state_d = par_en_q ? StParity : StStop;
         StParity: if (bit_end) state_d = StStop;
         StStop:   if (bit_end) state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   // Datapath and registered output pulses
   always_comb begin
      edge_cnt_d = edge_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      presc_d    = presc_q;
      par_en_d   = par_en_q;
      par_type_d = par_type_q;
      shift_d    = shift_q;
      p_data_d   = p_data_q;
      err_d      = err_q;
      samp_d     = samp_q;
      dv_d       = 1'b0;
      pe_d       = 1'b0;
      se_d       = 1'b0;
      if (state_q == StIdle) begin
         edge_cnt_d = '0;
         bit_cnt_d  = '0;
         err_d      = 1'b0;
         if (!RX_IN) begin
            presc_d    = (PRESCALE < PRESC_MIN) ? PRESC_MIN : PRESCALE;
            par_en_d   = PAR_ENABLE;
            par_type_d = PAR_TYPE;
         end
      end else begin
         edge_cnt_d = bit_end ? '0 : edge_cnt_q + ONE;
`ifdef UART_RX_MAJORITY_EN
         if (edge_cnt_q == half - ONE) samp_d[0] = RX_IN;
         if (edge_cnt_q == half)       samp_d[1] = RX_IN;
         if (edge_cnt_q == half + ONE) samp_d[2] = RX_IN;
`else
         if (edge_cnt_q == half) samp_d = RX_IN;
`endif
         if (bit_end) begin
            unique case (state_q)
               StData: begin
                  shift_d[bit_cnt_q] = bit_val;
                  bit_cnt_d          = bit_cnt_q + BW'(1);
               end
               StParity: begin
                  if (bit_val != ((^shift_q) ^ par_type_q)) begin
                     pe_d  = 1'b1;
                     err_d = 1'b1;
                  end
               end
               StStop: begin
                  if (!bit_val) begin
                     se_d = 1'b1;
                  end else if (!err_q) begin
                     dv_d     = 1'b1;
                     p_data_d = shift_q;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   // Datapath registers
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         edge_cnt_q <= '0;
         bit_cnt_q  <= '0;
         presc_q    <= PRESC_MIN;
         par_en_q   <= 1'b0;
         par_type_q <= 1'b0;
         shift_q    <= '0;
         p_data_q   <= '0;
         err_q      <= 1'b0;
         samp_q     <= '0;
         dv_q       <= 1'b0;
         pe_q       <= 1'b0;
         se_q       <= 1'b0;
      end else begin
         edge_cnt_q <= edge_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         presc_q    <= presc_d;
         par_en_q   <= par_en_d;
         par_type_q <= par_type_d;
         shift_q    <= shift_d;
         p_data_q   <= p_data_d;
         err_q      <= err_d;
         samp_q     <= samp_d;
         dv_q       <= dv_d;
         pe_q       <= pe_d;
         se_q       <= se_d;
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx (default 8 data bits).
module tb_uart_rx;

   logic       CLK = 1'b0;
   logic       RST;
   logic       RX_IN;
   logic [5:0] PRESCALE;
   logic       PAR_ENABLE;
   logic       PAR_TYPE;
   logic [7:0] P_DATA;
   logic       DATA_VALID;
   logic       PAR_ERR;
   logic       STP_ERR;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int dv_n, pe_n, se_n, dv_cyc, start_cyc;

   uart_rx dut (
      .CLK       (CLK),
      .RST       (RST),
      .RX_IN     (RX_IN),
      .PRESCALE  (PRESCALE),
      .PAR_ENABLE(PAR_ENABLE),
      .PAR_TYPE  (PAR_TYPE),
      .P_DATA    (P_DATA),
      .DATA_VALID(DATA_VALID),
      .PAR_ERR   (PAR_ERR),
      .STP_ERR   (STP_ERR)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc++;

   // Pulse counters sampled on the falling edge
   always @(negedge CLK) begin
      if (DATA_VALID) begin
         dv_n++;
         dv_cyc = cyc;
      end
      if (PAR_ERR) pe_n++;
      if (STP_ERR) se_n++;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0h want=%0h", tag, got, exp);
      end
   endtask

   task automatic clear_counts();
      @(posedge CLK);
      #1;
      dv_n = 0;
      pe_n = 0;
      se_n = 0;
      dv_cyc = -1;
   endtask

   // Drive one frame, one bit per presc cycles; glitch inverts data-bit cycle 9
   task automatic send_frame(input logic [7:0] d, input bit pen, input bit pbit,
                             input bit stop, input int presc, input bit glitch);
      logic [11:0] bits;
      int n;
      bits      = '0;
      bits[8:1] = d;
      if (pen) begin
         bits[9]  = pbit;
         bits[10] = stop;
         n = 11;
      end else begin
         bits[9] = stop;
         n = 10;
      end
      for (int i = 0; i < n; i++) begin
         for (int c = 0; c < presc; c++) begin
            @(negedge CLK);
            if (i == 0 && c == 0) start_cyc = cyc;
            RX_IN = bits[i] ^ (glitch && i >= 1 && i <= 8 && c == 9);
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge CLK);
         RX_IN = 1'b1;
      end
   endtask

   initial begin
      RST        = 1'b1;
      RX_IN      = 1'b1;
      PRESCALE   = 6'd8;
      PAR_ENABLE = 1'b0;
      PAR_TYPE   = 1'b0;
      dv_n = 0; pe_n = 0; se_n = 0; dv_cyc = -1; start_cyc = 0;
      #1 RST = 1'b0;
      #20;
      check("rst_pdata", 32'(P_DATA), 32'h0);
      check("rst_dv", 32'(DATA_VALID), 32'h0);
      check("rst_pe", 32'(PAR_ERR), 32'h0);
      check("rst_se", 32'(STP_ERR), 32'h0);
      @(negedge CLK);
      RST = 1'b1;
      idle(4);

      // 0xA5, no parity, prescale 8
      clear_counts();
      send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 8, 1'b0);
      idle(16);
      check("a5_dv_cnt", 32'(dv_n), 32'd1);
      check("a5_latency", 32'(dv_cyc - (start_cyc + 1)), 32'd80);
      check("a5_pdata", 32'(P_DATA), 32'hA5);
      check("a5_pe_cnt", 32'(pe_n), 32'd0);
      check("a5_se_cnt", 32'(se_n), 32'd0);

      // 0x3C, even parity, wrong parity bit
      PRESCALE = 6'd16; PAR_ENABLE = 1'b1; PAR_TYPE = 1'b0;
      clear_counts();
      send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 16, 1'b0);
      idle(32);
      check("par_pe_cnt", 32'(pe_n), 32'd1);
      check("par_dv_cnt", 32'(dv_n), 32'd0);
      check("par_pdata", 32'(P_DATA), 32'hA5);

      // 0x3C, odd parity, correct parity bit
      PAR_TYPE = 1'b1;
      clear_counts();
      send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 16, 1'b0);
      idle(32);
      check("odd_dv_cnt", 32'(dv_n), 32'd1);
      check("odd_pe_cnt", 32'(pe_n), 32'd0);
      check("odd_pdata", 32'(P_DATA), 32'h3C);

      // 0x55 with stop bit low
      PRESCALE = 6'd8; PAR_ENABLE = 1'b0; PAR_TYPE = 1'b0;
      clear_counts();
      send_frame(8'h55, 1'b0, 1'b0, 1'b0, 8, 1'b0);
      idle(16);
      check("stp_se_cnt", 32'(se_n), 32'd1);
      check("stp_dv_cnt", 32'(dv_n), 32'd0);
      check("stp_pdata", 32'(P_DATA), 32'h3C);

      // False start: two low cycles only
      clear_counts();
      @(negedge CLK); RX_IN = 1'b0;
      @(negedge CLK); RX_IN = 1'b0;
      idle(20);
      check("false_dv_cnt", 32'(dv_n), 32'd0);
      check("false_err_cnt", 32'(pe_n + se_n), 32'd0);
      send_frame(8'h0F, 1'b0, 1'b0, 1'b1, 8, 1'b0);
      idle(16);
      check("false_next_dv", 32'(dv_n), 32'd1);
      check("false_next_pdata", 32'(P_DATA), 32'h0F);

      // PRESCALE below minimum runs at 8 cycles per bit
      PRESCALE = 6'd4;
      clear_counts();
      send_frame(8'hC3, 1'b0, 1'b0, 1'b1, 8, 1'b0);
      idle(16);
      check("pmin_dv_cnt", 32'(dv_n), 32'd1);
      check("pmin_pdata", 32'(P_DATA), 32'hC3);
      PRESCALE = 6'd8;

      // Back-to-back frames with no idle gap
      clear_counts();
      send_frame(8'h12, 1'b0, 1'b0, 1'b1, 8, 1'b0);
      send_frame(8'h34, 1'b0, 1'b0, 1'b1, 8, 1'b0);
      idle(16);
      check("b2b_dv_cnt", 32'(dv_n), 32'd2);
      check("b2b_pdata", 32'(P_DATA), 32'h34);

      // Reset during data bit 4 of 0xFF
      fork
         send_frame(8'hFF, 1'b0, 1'b0, 1'b1, 8, 1'b0);
         begin
            repeat (43) @(negedge CLK);
            #2 RST = 1'b0;
            #1;
            check("mid_rst_pdata", 32'(P_DATA), 32'h0);
            check("mid_rst_flags", 32'({DATA_VALID, PAR_ERR, STP_ERR}), 32'h0);
            repeat (2) @(negedge CLK);
            RST = 1'b1;
         end
      join
      idle(16);
      clear_counts();
      send_frame(8'h81, 1'b0, 1'b0, 1'b1, 8, 1'b0);
      idle(16);
      check("post_rst_dv", 32'(dv_n), 32'd1);
      check("post_rst_pdata", 32'(P_DATA), 32'h81);

      // Mid-bit glitch on every data bit of 0x96
      PRESCALE = 6'd16;
      clear_counts();
      send_frame(8'h96, 1'b0, 1'b0, 1'b1, 16, 1'b1);
      idle(32);
      check("glitch_dv_cnt", 32'(dv_n), 32'd1);
`ifdef UART_RX_MAJORITY_EN
      check("glitch_pdata", 32'(P_DATA), 32'h96);
`else
      check("glitch_pdata", 32'(P_DATA), 32'h69);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
